// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue, held pending, and committed when the busy count expires.
`timescale 1ns/1ps
module mul_div_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_ok_q, pend_ok_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PW-1:0]    a_ext, b_ext, prod;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] abs_a, abs_b, div_b, q_mag, r_mag, quo, rem;

    // Datapath: full-width product and sign-magnitude division of the issuing operands
    always_comb begin
        if (op == OP_MULT) begin
            a_ext = {{WIDTH{operand1[WIDTH-1]}}, operand1};
            b_ext = {{WIDTH{operand2[WIDTH-1]}}, operand2};
        end else begin
            a_ext = {{WIDTH{1'b0}}, operand1};
            b_ext = {{WIDTH{1'b0}}, operand2};
        end
        prod  = a_ext * b_ext;

        neg_a = (op == OP_DIV) && operand1[WIDTH-1];
        neg_b = (op == OP_DIV) && operand2[WIDTH-1];
        abs_a = neg_a ? (-operand1) : operand1;
        abs_b = neg_b ? (-operand2) : operand2;
        // Zero divisor is replaced so the divider never sees it; the result is discarded anyway
        div_b = (abs_b == '0) ? WIDTH'(1) : abs_b;
        q_mag = abs_a / div_b;
        r_mag = abs_a % div_b;
        quo   = (neg_a ^ neg_b) ? (-q_mag) : q_mag;
        rem   = neg_a ? (-r_mag) : r_mag;
    end

    // Issue, countdown and commit control
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;

        if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (pend_ok_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    pend_hi_d = prod[PW-1:WIDTH];
                    pend_lo_d = prod[WIDTH-1:0];
                    pend_ok_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                    busy_d    = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi_d = rem;
                    pend_lo_d = quo;
                    pend_ok_d = (operand2 != '0);
                    cnt_d     = CNT_W'(DIV_CYCLES);
                    busy_d    = 1'b1;
                end
                OP_MTHI: hi_d = operand1;
                OP_MTLO: lo_d = operand1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: issued ops push expected HI/LO and busy length,
// a negedge monitor pops and compares whenever busy falls.
`timescale 1ns/1ps
module tb_mul_div_unit;

    localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                           DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = NOP;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo;

    logic        start1 = 1'b0;
    logic [2:0]  op1 = NOP;
    logic [31:0] a1 = '0, b1 = '0;
    logic        busy1;
    logic [31:0] hi1, lo1;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand1(a), .operand2(b), .busy(busy), .hi(hi), .lo(lo)
    );

    mul_div_unit #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op1),
        .operand1(a1), .operand2(b1), .busy(busy1), .hi(hi1), .lo(lo1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Monitor: every busy fall is a commit and must match the oldest expectation
    int run_len = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            run_len   = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                run_len++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("commit_hi", hi, e.hi);
                    check("commit_lo", lo, e.lo);
                    check("busy_len", 32'(run_len), 32'(e.cyc));
                end
                run_len = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = NOP;
    endtask

    task automatic expect_commit(input logic [31:0] eh, input logic [31:0] el, input int n);
        exp_t e;
        e.hi = eh; e.lo = el; e.cyc = n;
        exp_q.push_back(e);
    endtask

    // Returns at the first negedge where busy is low
    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);

        // Abort an in-flight MULT with reset; its result must never appear
        issue(MULT, 32'd9, 32'd9);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        repeat (12) @(negedge clk);
        check("abort_late_hi", hi, 32'h0);
        check("abort_late_lo", lo, 32'h0);
        check("abort_late_busy", 32'(busy), 32'd0);

        expect_commit(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue(MULT, 32'hFFFFFFFE, 32'h3);
        wait_idle();
        expect_commit(32'h00000002, 32'hFFFFFFFA, 5);
        issue(MULTU, 32'hFFFFFFFE, 32'h3);
        wait_idle();
        expect_commit(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(DIV, 32'hFFFFFFF9, 32'h2);
        wait_idle();
        expect_commit(32'h1, 32'h3, 10);
        issue(DIVU, 32'h7, 32'h2);
        wait_idle();

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1; op = MTHI; a = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_busy", 32'(busy), 32'd0);
        op = MTLO; a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0; op = NOP;
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        check("mtlo_hi", hi, 32'h12345678);
        check("mtlo_busy", 32'(busy), 32'd0);

        expect_commit(32'h12345678, 32'h9ABCDEF0, 10);
        issue(DIV, 32'h55, 32'h0);
        wait_idle();

        // Starts during busy are ignored; a DIVU right after busy falls is accepted
        expect_commit(32'h0, 32'd42, 5);
        issue(MULT, 32'd6, 32'd7);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd3;
        @(negedge clk);
        op = MTLO; a = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; op = NOP;
        wait_idle();
        expect_commit(32'd2, 32'd14, 10);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = NOP;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_idle();

        expect_commit(32'h0, 32'h80000000, 10);
        issue(DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        @(negedge clk);

        // Single-cycle latency instance
        @(negedge clk);
        start1 = 1'b1; op1 = MULT; a1 = 32'hFFFFFFFE; b1 = 32'h3;
        @(negedge clk);
        start1 = 1'b0; op1 = NOP;
        check("p1_mult_busy_hi", 32'(busy1), 32'd1);
        @(negedge clk);
        check("p1_mult_busy_lo", 32'(busy1), 32'd0);
        check("p1_mult_hi", hi1, 32'hFFFFFFFF);
        check("p1_mult_lo", lo1, 32'hFFFFFFFA);
        start1 = 1'b1; op1 = DIVU; a1 = 32'd7; b1 = 32'd2;
        @(negedge clk);
        start1 = 1'b0; op1 = NOP;
        check("p1_div_busy_hi", 32'(busy1), 32'd1);
        @(negedge clk);
        check("p1_div_busy_lo", 32'(busy1), 32'd0);
        check("p1_div_hi", hi1, 32'd1);
        check("p1_div_lo", lo1, 32'd3);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage, alongside the ALU. Holds the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU with parametrised latency, plus MTHI/MTLO writes.
- Exposes `busy` so hazard control can stall dependent MD instructions. HI/LO are read combinationally by MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).
- CNT_W, 8, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  issue strobe; qualifies op for one cycle.
- op  input  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- operand1  input  WIDTH  rs value (multiplicand/dividend/MT source).
- operand2  input  WIDTH  rt value (multiplier/divisor).
- busy  output  1  registered; high while an operation is in flight.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.

Behaviour:
- Reset (reset==0 at an edge): hi=0, lo=0, busy=0, counter=0, pending result cleared. Reset overrides start and aborts any in-flight operation; the aborted result is never committed.
- Idle: busy==0.
- Issue of MULT/MULTU/DIV/DIVU (start==1 and busy==0 at edge E0):
  - The full result is computed from the operands sampled at E0 and latched into pending_hi/pending_lo.
  - counter is loaded with N (MULT_CYCLES or DIV_CYCLES) and busy goes to 1.
- Run: at each later edge with busy==1, counter decrements. At the edge where counter==1:
  - hi<=pending_hi, lo<=pending_lo, busy<=0, counter<=0.
  - busy is therefore high for exactly N cycles, and new HI/LO are visible in the same cycle busy falls.
- MTHI/MTLO (start==1, busy==0): hi (or lo) <= operand1 at that edge. busy stays 0; latency is 1 edge.
- start while busy==1: ignored entirely, for any op. Hazard control must stall; the unit does not queue.
- NOP or reserved op with start==1: no state change.
- start==0: op and operands are don't-care.
- MULT: signed WIDTH×WIDTH -> 2·WIDTH product; hi=upper half, lo=lower half.
- MULTU: the same as MULT, unsigned.
- DIV (signed):
  - lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - Overflow case (most-negative / -1): lo=most-negative value, hi=0.
- DIVU: lo=unsigned quotient, hi=unsigned remainder.
- Divide by zero (DIV or DIVU, operand2==0):
  - The operation still runs the full DIV_CYCLES and busy behaves normally.
  - hi and lo are left unchanged at commit.
- Back-to-back issue: a new start is accepted in the cycle busy has just fallen, i.e. at the edge after commit. The committed HI/LO are visible to MFHI/MFLO in that same cycle.
- hi and lo outputs are pure register outputs. There is no bypass of pending values.

Test Plan:
- Reset low for 2 cycles with an op in flight -> hi=0, lo=0, busy=0. No commit occurs afterwards even after N cycles.
- MULT operand1=0xFFFFFFFE (-2), operand2=0x00000003 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV operand1=0xFFFFFFF9 (-7), operand2=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge after each, busy never asserts. DIV by 0 afterwards -> busy high 10 cycles, hi/lo still 0x12345678/0x9ABCDEF0.
- start MULT, then start DIVU and MTLO during busy -> both ignored; only the MULT result commits after 5 cycles. A DIVU issued in the busy-fall cycle's next edge is accepted.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Parameter sweep MULT_CYCLES=1, DIV_CYCLES=1 -> busy high exactly 1 cycle per operation.
